axi_lite_if_ext: RTL and testbench
==================================

Name: axi_lite_if_ext

Overview:
Parametrised successor AXI4-Lite slave front-end that bridges an AXI4-Lite master to the reg_bank register port.
- Write side: AW and W are accepted independently, in either order, through one-deep holding registers.
- Address decode: checks register count, alignment and protection; illegal accesses are answered with SLVERR and never reach reg_bank.
- Read side: a watchdog turns a missing reg_read_valid into an SLVERR response instead of a bus hang.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32: AXI address width.
- C_S_AXI_DATA_WIDTH, 32: data width, 32 or 64; ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
- C_NUM_REGS, 16: number of decoded word registers; legal word index is 0..C_NUM_REGS-1.
- C_CHECK_ALIGN, 1: when 1, nonzero address bits [ADDR_LSB-1:0] are a decode error.
- C_SECURE_ONLY, 0: when 1, AxPROT[1]=1 (non-secure) is a decode error.
- C_RD_TIMEOUT, 16: reg_read_valid wait limit in cycles; 0 disables the watchdog.

Ports:
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESET in 1: synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID in, AW/3/1; S_AXI_AWREADY out 1: write address channel.
- S_AXI_WDATA/WSTRB/WVALID in, DW/DW/8/1; S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID in, AW/3/1; S_AXI_ARREADY out 1: read address channel.
- S_AXI_RDATA out DW; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.
- reg_write_en out 1: one-cycle write strobe; reg_write_addr out AW; reg_write_data out DW; reg_write_strb out DW/8.
- reg_read_en out 1: one-cycle read strobe; reg_read_addr out AW; reg_read_data in DW; reg_read_valid in 1.
- wr_err out 1: one-cycle pulse with each SLVERR write response.
- rd_err out 1: one-cycle pulse with each SLVERR read response.

Behaviour:
Reset:
- While S_AXI_ARESET=1 at a clock edge, all outputs, holding registers, flags and counters go to 0; BRESP/RRESP=OKAY(00).
- Reset mid-transaction drops the transaction silently; no response is issued afterwards.

Decode error (err):
- Word index addr[AW-1:ADDR_LSB] >= C_NUM_REGS, or
- alignment violation when C_CHECK_ALIGN=1, or
- PROT[1]=1 when C_SECURE_ONLY=1.

Write path:
- Flags aw_full and w_full.
- AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID. Both are derived from registered state only, never from VALID.
- AW handshake captures AWADDR/AWPROT and sets aw_full. W handshake captures WDATA/WSTRB and sets w_full. Same-cycle and either-order arrival are all legal.
- Edge after both flags are set:
  - BVALID=1 and both flags clear.
  - If err: BRESP=SLVERR and wr_err=1; reg_write_en stays 0.
  - Otherwise, with WSTRB nonzero: reg_write_en=1 for one cycle with the held addr/data/strb; BRESP=OKAY.
  - Otherwise (WSTRB=0): reg_write_en stays 0; BRESP=OKAY.
- Latency: AW and W accepted at edge N gives BVALID and reg_write_en at edge N+1.
- BVALID and BRESP hold until the BREADY handshake; BVALID falls at the following edge.
- A new AW/W is accepted only after BVALID falls; maximum one write outstanding.

Read FSM:
- R_IDLE: ARREADY=1. The ARVALID handshake captures ARADDR.
  - If err: go to R_RESP with RVALID=1, RRESP=SLVERR, RDATA=0, rd_err=1.
  - Otherwise: reg_read_en=1 for one cycle, clear the counter, go to R_WAIT.
- R_WAIT: ARREADY=0. reg_read_valid is sampled every cycle, including the cycle reg_read_en is high.
  - If valid: latch reg_read_data into RDATA, RRESP=OKAY, RVALID=1, go to R_RESP.
  - Otherwise the counter increments. If C_RD_TIMEOUT>0 and C_RD_TIMEOUT cycles elapse without valid: RDATA=0, RRESP=SLVERR, rd_err=1, go to R_RESP.
  - Valid arriving on the final counted cycle wins over the timeout.
- R_RESP: RVALID, RDATA and RRESP are stable until the RREADY handshake, then R_IDLE with RVALID=0.
- reg_read_valid outside R_WAIT is ignored.
- Read and write paths are fully independent; simultaneous AR and AW/W are allowed.
- reg_read_addr and reg_write_addr hold their last captured value.

Test Plan:
- AW(0x08) and W(0xA5A5_0001, strb F) in the same cycle → reg_write_en one cycle later with addr 0x08, data 0xA5A5_0001; BVALID the same edge, BRESP=00.
- W accepted 3 cycles before AW(0x0C); BREADY held low for 4 cycles → single reg_write_en; BVALID held 4 cycles; AWREADY/WREADY stay 0 until BVALID falls.
- Write to 0x40 (index 16), 0x05 (misaligned), and AWPROT=3'b010 with C_SECURE_ONLY=1 → no reg_write_en; BRESP=10; wr_err pulses each time.
- Read 0x04 with reg_read_valid 2 cycles after reg_read_en, data 0x1234_5678 → RDATA=0x1234_5678, RRESP=00; reg_read_valid in the same cycle as reg_read_en → 1-cycle-earlier RVALID.
- Read 0x04, reg_read_valid never asserted, C_RD_TIMEOUT=16 → RVALID after 16 wait cycles, RRESP=10, RDATA=0, rd_err pulse; valid on cycle 16 → OKAY.
- S_AXI_ARESET asserted in R_WAIT and with aw_full set → all outputs 0 next edge; no late B/R response; next transaction completes normally.

Source files
------------

// File: rtl/axi_lite_if_ext_if.sv
// axi_lite_if_ext_if
// AXI4-Lite bus bundle between a master and the axi_lite_if_ext slave.
// Parameters: AW = address width, DW = data width (32 or 64).
// Modports:
//   master - drives AW/W/AR channel payloads and VALIDs plus BREADY/RREADY
//   slave  - drives AWREADY/WREADY/ARREADY and the B/R channel responses
interface axi_lite_if_ext_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   AWADDR;
  logic [2:0]      AWPROT;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [AW-1:0]   ARADDR;
  logic [2:0]      ARPROT;
  logic            ARVALID;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_if_ext.sv
// axi_lite_if_ext
// AXI4-Lite slave front-end bridging an AXI4-Lite master to the reg_bank
// register port. AW and W are buffered independently (one entry each) and a
// write is issued once both are held. Illegal addresses (out of range,
// misaligned, non-secure when secure-only) are answered with SLVERR and never
// reach reg_bank. Reads are guarded by a watchdog that converts a missing
// reg_read_valid into an SLVERR response.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   s_axi                     : AXI4-Lite slave modport
//   reg_write_*               : one-cycle write strobe with held addr/data/strb
//   reg_read_en / _addr       : one-cycle read strobe with held address
//   reg_read_data / _valid    : read return from reg_bank
//   wr_err / rd_err           : one-cycle pulse with each SLVERR response
module axi_lite_if_ext #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 16,
  parameter int C_CHECK_ALIGN      = 1,
  parameter int C_SECURE_ONLY      = 0,
  parameter int C_RD_TIMEOUT       = 16
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESET,
  axi_lite_if_ext_if.slave                    s_axi,
  output logic                                reg_write_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]       reg_write_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg_write_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]     reg_write_strb,
  output logic                                reg_read_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]       reg_read_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       reg_read_data,
  input  logic                                reg_read_valid,
  output logic                                wr_err,
  output logic                                rd_err
);
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int CNT_W    = $clog2(C_RD_TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((C_RD_TIMEOUT > 0) ? (C_RD_TIMEOUT - 1) : 0);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  // Decode error: word index out of range, misaligned, or non-secure access.
  function automatic logic decode_err(input logic [AW-1:0] addr, input logic non_secure);
    logic [AW-1:0] idx;
    logic          bad_idx;
    logic          bad_align;
    logic          bad_prot;
    idx       = addr >> ADDR_LSB;
    bad_idx   = (idx >= AW'(C_NUM_REGS));
    bad_align = (C_CHECK_ALIGN != 0) && (addr[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}});
    bad_prot  = (C_SECURE_ONLY != 0) && non_secure;
    return bad_idx || bad_align || bad_prot;
  endfunction

  // write-side state
  logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic          awns_q, awns_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, wr_err_q, wr_err_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [SW-1:0] wstb_q, wstb_d;
  // read-side state
  rstate_e       rstate_q, rstate_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic          rvalid_q, rvalid_d, rd_err_q, rd_err_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ren_q, ren_d;
  logic [AW-1:0] raddr_q, raddr_d;

  logic awready_s, wready_s, aw_hs_s, w_hs_s;

  // Readiness comes from registered flags only, so no VALID->READY path exists.
  assign awready_s = !aw_full_q && !bvalid_q;
  assign wready_s  = !w_full_q && !bvalid_q;
  assign aw_hs_s   = s_axi.AWVALID && awready_s;
  assign w_hs_s    = s_axi.WVALID && wready_s;

  // Write path next state: buffer AW/W, issue the write once both are held.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    awaddr_d  = awaddr_q;
    awns_d    = awns_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_err_d  = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdat_d    = wdat_q;
    wstb_d    = wstb_q;
    if (aw_hs_s) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi.AWADDR;
      awns_d    = s_axi.AWPROT[1];
    end else begin
      aw_full_d = aw_full_q;
    end
    if (w_hs_s) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.WDATA;
      wstrb_d  = s_axi.WSTRB;
    end else begin
      w_full_d = w_full_q;
    end
    // Both flags set implies BVALID is low: flags only set while BVALID=0.
    if (aw_full_q && w_full_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (decode_err(awaddr_q, awns_q)) begin
        bresp_d  = RESP_SLVERR;
        wr_err_d = 1'b1;
      end else begin
        bresp_d = RESP_OKAY;
        // An all-zero strobe is acknowledged but not forwarded.
        wen_d   = (wstrb_q != {SW{1'b0}});
        if (wstrb_q != {SW{1'b0}}) begin
          waddr_d = awaddr_q;
          wdat_d  = wdata_q;
          wstb_d  = wstrb_q;
        end else begin
          waddr_d = waddr_q;
        end
      end
    end else if (bvalid_q && s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Read FSM next state and outputs.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rd_err_d = 1'b0;
    ren_d    = 1'b0;
    raddr_d  = raddr_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi.ARVALID) begin
          if (decode_err(s_axi.ARADDR, s_axi.ARPROT[1])) begin
            rstate_d = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = {DW{1'b0}};
            rd_err_d = 1'b1;
          end else begin
            ren_d    = 1'b1;
            raddr_d  = s_axi.ARADDR;
            rcnt_d   = {CNT_W{1'b0}};
            rstate_d = R_WAIT;
          end
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_WAIT: begin
        // Valid is checked first so it wins on the final counted cycle.
        if (reg_read_valid) begin
          rdata_d  = reg_read_data;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
        end else if ((C_RD_TIMEOUT > 0) && (rcnt_q == RD_LAST)) begin
          rdata_d  = {DW{1'b0}};
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          rd_err_d = 1'b1;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_axi.RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_RESP;
        end
      end
      default: begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any transaction in flight.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;  w_full_q <= 1'b0;
      awaddr_q  <= '0;    awns_q   <= 1'b0;
      wdata_q   <= '0;    wstrb_q  <= '0;
      bvalid_q  <= 1'b0;  bresp_q  <= RESP_OKAY;  wr_err_q <= 1'b0;
      wen_q     <= 1'b0;  waddr_q  <= '0;  wdat_q <= '0;  wstb_q <= '0;
      rstate_q  <= R_IDLE; rcnt_q  <= '0;
      rvalid_q  <= 1'b0;  rresp_q  <= RESP_OKAY;  rdata_q <= '0;
      rd_err_q  <= 1'b0;  ren_q    <= 1'b0;  raddr_q <= '0;
    end else begin
      aw_full_q <= aw_full_d; w_full_q <= w_full_d;
      awaddr_q  <= awaddr_d;  awns_q   <= awns_d;
      wdata_q   <= wdata_d;   wstrb_q  <= wstrb_d;
      bvalid_q  <= bvalid_d;  bresp_q  <= bresp_d;  wr_err_q <= wr_err_d;
      wen_q     <= wen_d;     waddr_q  <= waddr_d;  wdat_q <= wdat_d;  wstb_q <= wstb_d;
      rstate_q  <= rstate_d;  rcnt_q   <= rcnt_d;
      rvalid_q  <= rvalid_d;  rresp_q  <= rresp_d;  rdata_q <= rdata_d;
      rd_err_q  <= rd_err_d;  ren_q    <= ren_d;    raddr_q <= raddr_d;
    end
  end

  assign s_axi.AWREADY = awready_s;
  assign s_axi.WREADY  = wready_s;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = (rstate_q == R_IDLE);
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;
  assign reg_write_en   = wen_q;
  assign reg_write_addr = waddr_q;
  assign reg_write_data = wdat_q;
  assign reg_write_strb = wstb_q;
  assign reg_read_en    = ren_q;
  assign reg_read_addr  = raddr_q;
  assign wr_err         = wr_err_q;
  assign rd_err         = rd_err_q;
endmodule

// File: tb/tb_axi_lite_if_ext.sv
// tb_axi_lite_if_ext
// Directed bench for axi_lite_if_ext (secure-only, 16 registers, timeout 16).
// A small reg_bank responder returns data after a programmable delay; an
// address-rule model predicts response codes, latencies and forwarded writes.
module tb_axi_lite_if_ext;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en, reg_read_en, reg_read_valid, wr_err, rd_err;
  logic [31:0] reg_write_addr, reg_write_data, reg_read_addr, reg_read_data;
  logic [3:0]  reg_write_strb;
  int          checks = 0;
  int          failures = 0;
  int          rv_delay = -1;
  logic [31:0] bank [16];

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  wr_t         got_wr;

  always #5 clk = ~clk;

  axi_lite_if_ext_if #(.AW(32), .DW(32)) bus ();

  axi_lite_if_ext #(
    .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_NUM_REGS(16),
    .C_CHECK_ALIGN(1), .C_SECURE_ONLY(1), .C_RD_TIMEOUT(16)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .reg_write_strb(reg_write_strb),
    .reg_read_en(reg_read_en), .reg_read_addr(reg_read_addr),
    .reg_read_data(reg_read_data), .reg_read_valid(reg_read_valid),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address rules: 16 word registers, word aligned, non-secure rejected.
  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] p);
    return ((a / 32'd4) >= 32'd16) || ((a % 32'd4) != 32'd0) || (p[1] == 1'b1);
  endfunction

  // reg_bank responder: valid appears rv_delay cycles after the read strobe.
  initial begin
    reg_read_valid = 1'b0;
    reg_read_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (reg_read_en === 1'b1 && rv_delay >= 0) begin
        if (rv_delay > 0) begin
          repeat (rv_delay) @(posedge clk);
          #1;
        end
        reg_read_valid = 1'b1;
        reg_read_data  = bank[reg_read_addr[5:2]];
        @(posedge clk); #1;
        reg_read_valid = 1'b0;
        reg_read_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Per-cycle compare against the predicted reg_bank traffic and protocol rules.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (reg_write_en === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          got_wr = exp_wr_q.pop_front();
          chk("wr_addr", {32'h0, reg_write_addr}, {32'h0, got_wr.a});
          chk("wr_data", {32'h0, reg_write_data}, {32'h0, got_wr.d});
          chk("wr_strb", {60'h0, reg_write_strb}, {60'h0, got_wr.s});
          chk("wr_with_bvalid", {63'h0, bus.BVALID}, 64'd1);
        end
      end
      if (reg_read_en === 1'b1) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else chk("rd_addr", {32'h0, reg_read_addr}, {32'h0, exp_rd_q.pop_front()});
      end
      if (bus.BVALID === 1'b1) chk("b_blocks_aw_w", {62'h0, bus.AWREADY, bus.WREADY}, 64'd0);
      if (wr_err === 1'b1) chk("wr_err_resp", {61'h0, bus.BVALID, bus.BRESP}, 64'h6);
      if (bus.RVALID === 1'b1) chk("r_blocks_ar", {63'h0, bus.ARREADY}, 64'd0);
      if (rd_err === 1'b1) chk("rd_err_resp", {60'h0, bus.RVALID, bus.RRESP, (bus.RDATA == 32'h0)}, 64'hD);
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, input int b_hold,
                          output logic [1:0] bresp_o);
    bit         err;
    wr_t        e;
    logic [1:0] exp_resp;
    err      = exp_err(a, p);
    exp_resp = err ? 2'b10 : 2'b00;
    if (!err && s != 4'h0) begin
      e.a = a; e.d = d; e.s = s;
      exp_wr_q.push_back(e);
    end
    chk("w_idle_ready", {62'h0, bus.AWREADY, bus.WREADY}, 64'h3);
    if (w_lead > 0) begin
      bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
      @(posedge clk); #1;
      bus.WVALID = 1'b0;
      for (int i = 0; i < w_lead - 1; i++) begin
        chk("w_held_aw_ready", {61'h0, bus.AWREADY, bus.WREADY, bus.BVALID}, 64'h4);
        @(posedge clk); #1;
      end
      chk("w_held_aw_ready", {61'h0, bus.AWREADY, bus.WREADY, bus.BVALID}, 64'h4);
      bus.AWADDR = a; bus.AWPROT = p; bus.AWVALID = 1'b1;
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
    end else begin
      bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
      bus.AWADDR = a; bus.AWPROT = p; bus.AWVALID = 1'b1;
      @(posedge clk); #1;
      bus.WVALID = 1'b0; bus.AWVALID = 1'b0;
    end
    chk("w_accepted_no_b", {61'h0, bus.BVALID, bus.AWREADY, bus.WREADY}, 64'h0);
    @(posedge clk); #1;
    chk("bvalid_rise", {63'h0, bus.BVALID}, 64'd1);
    chk("bresp", {62'h0, bus.BRESP}, {62'h0, exp_resp});
    chk("wr_err_pulse", {63'h0, wr_err}, {63'h0, err});
    chk("wr_en", {63'h0, reg_write_en}, {63'h0, (!err && s != 4'h0)});
    bresp_o = bus.BRESP;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      chk("b_hold", {59'h0, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {59'h0, 1'b1, exp_resp, 2'b00});
      chk("b_hold_quiet", {62'h0, wr_err, reg_write_en}, 64'h0);
    end
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk("b_done", {61'h0, bus.BVALID, bus.AWREADY, bus.WREADY}, 64'h3);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int dly,
                         input int r_hold, output logic [31:0] rdata_o,
                         output logic [1:0] rresp_o, output int lat_o);
    bit          err, tmo;
    int          exp_lat, n;
    logic [31:0] exp_data;
    err      = exp_err(a, p);
    tmo      = !err && (dly < 0 || dly >= 16);
    exp_lat  = err ? 0 : (tmo ? 16 : dly + 1);
    exp_data = (err || tmo) ? 32'h0 : bank[a[5:2]];
    if (!err) exp_rd_q.push_back(a);
    rv_delay = dly;
    chk("ar_idle_ready", {63'h0, bus.ARREADY}, 64'd1);
    bus.ARADDR = a; bus.ARPROT = p; bus.ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    n = 0;
    while (bus.RVALID !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("r_latency", 64'(n), 64'(exp_lat));
    chk("rresp", {62'h0, bus.RRESP}, {62'h0, ((err || tmo) ? 2'b10 : 2'b00)});
    chk("rdata", {32'h0, bus.RDATA}, {32'h0, exp_data});
    chk("rd_err_pulse", {63'h0, rd_err}, {63'h0, (err || tmo)});
    rdata_o = bus.RDATA; rresp_o = bus.RRESP; lat_o = n;
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      chk("r_hold", {29'h0, bus.RVALID, bus.RRESP, bus.RDATA}, {29'h0, 1'b1, rresp_o, rdata_o});
      chk("r_hold_quiet", {63'h0, rd_err}, 64'd0);
    end
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    chk("r_done", {62'h0, bus.RVALID, bus.ARREADY}, 64'h1);
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          lat;
    for (int i = 0; i < 16; i++) bank[i] = 32'h1000_0000 + 32'(i);
    bank[1] = 32'h1234_5678;
    rst = 1'b1;
    bus.AWADDR = 32'h0; bus.AWPROT = 3'h0; bus.AWVALID = 1'b0;
    bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = 32'h0; bus.ARPROT = 3'h0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {56'h0, bus.BVALID, bus.RVALID, reg_write_en, reg_read_en, wr_err, rd_err, 2'b00}, 64'h0);
    chk("rst_resp", {32'h0, bus.BRESP, bus.RRESP, bus.RDATA[27:0]}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {61'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 64'h7);

    // writes
    do_write(32'h08, 3'b000, 32'hA5A5_0001, 4'hF, 0, 0, br);
    chk("pin_w1_resp", {62'h0, br}, 64'h0);
    chk("pin_w1_addr", {32'h0, reg_write_addr}, 64'h08);
    chk("pin_w1_data", {32'h0, reg_write_data}, 64'hA5A5_0001);
    do_write(32'h0C, 3'b000, 32'hCAFE_F00D, 4'h3, 3, 3, br);
    chk("pin_w2_addr", {32'h0, reg_write_addr}, 64'h0C);
    do_write(32'h40, 3'b000, 32'h1111_1111, 4'hF, 0, 0, br);
    chk("pin_w_range_resp", {62'h0, br}, 64'h2);
    do_write(32'h05, 3'b000, 32'h2222_2222, 4'hF, 2, 1, br);
    chk("pin_w_align_resp", {62'h0, br}, 64'h2);
    do_write(32'h10, 3'b010, 32'h3333_3333, 4'hF, 0, 0, br);
    chk("pin_w_prot_resp", {62'h0, br}, 64'h2);
    do_write(32'h14, 3'b000, 32'h4444_4444, 4'h0, 0, 0, br);
    chk("pin_w_strb0_resp", {62'h0, br}, 64'h0);
    chk("pin_w_held_data", {32'h0, reg_write_data}, 64'hCAFE_F00D);

    // reads
    do_read(32'h04, 3'b000, 2, 2, rd, rr, lat);
    chk("pin_r1_data", {32'h0, rd}, 64'h1234_5678);
    chk("pin_r1_lat", 64'(lat), 64'd3);
    do_read(32'h04, 3'b000, 0, 0, rd, rr, lat);
    chk("pin_r0_lat", 64'(lat), 64'd1);
    do_read(32'h04, 3'b000, -1, 1, rd, rr, lat);
    chk("pin_tmo_resp", {30'h0, rr, rd}, {30'h0, 2'b10, 32'h0});
    chk("pin_tmo_lat", 64'(lat), 64'd16);
    do_read(32'h04, 3'b000, 15, 0, rd, rr, lat);
    chk("pin_last_cycle_resp", {62'h0, rr}, 64'h0);
    do_read(32'h08, 3'b000, 16, 0, rd, rr, lat);
    do_read(32'h44, 3'b000, 0, 0, rd, rr, lat);
    chk("pin_r_range_lat", 64'(lat), 64'd0);
    do_read(32'h3C, 3'b010, 0, 0, rd, rr, lat);
    do_read(32'h3C, 3'b001, 1, 0, rd, rr, lat);

    // reset with a read waiting and an AW held
    rv_delay = -1;
    exp_rd_q.push_back(32'h0C);
    bus.ARADDR = 32'h0C; bus.ARPROT = 3'b000; bus.ARVALID = 1'b1;
    bus.AWADDR = 32'h10; bus.AWPROT = 3'b000; bus.AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", {61'h0, bus.ARREADY, bus.AWREADY, bus.WREADY}, 64'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outputs", {56'h0, bus.BVALID, bus.RVALID, reg_write_en, reg_read_en, wr_err, rd_err, 2'b00}, 64'h0);
    chk("mid_rst_addr", {reg_read_addr, reg_write_addr}, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("no_late_resp", {62'h0, bus.BVALID, bus.RVALID}, 64'h0);
    end
    do_write(32'h18, 3'b000, 32'h5555_AAAA, 4'hC, 0, 0, br);
    chk("post_rst_w_addr", {32'h0, reg_write_addr}, 64'h18);
    do_read(32'h04, 3'b000, 1, 0, rd, rr, lat);
    chk("post_rst_r_data", {32'h0, rd}, 64'h1234_5678);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
